// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the multiplexed hex display scanner (DISP_SCAN_LZB_EN enables leading-zero blanking)
package disp_pkg;
  localparam int NDIG_DEF = 4;
  localparam int DIV_DEF = 50000;
  localparam int NIB = 4;
`ifdef DISP_SCAN_LZB_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif
endpackage

// File: rtl/disp_tick.sv
// disp_tick: free-running prescaler, tick high during the last cycle of each DIV-cycle slot
module disp_tick #(
  parameter int DIV = disp_pkg::DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  // wrap the count at DIV-1 and flag that cycle as the tick
  always_comb begin
    tick = cnt_q == W'(DIV - 1);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end
  // prescaler state
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/disp_scan.sv
// disp_scan: NDIG-digit hex display scanner with tear-free frame-synchronous updates (DISP_SCAN_LZB_EN enables leading-zero blanking)
module disp_scan
  import disp_pkg::*;
#(
  parameter int NDIG = NDIG_DEF,
  parameter int DIV = DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [NIB*NDIG-1:0]   value,
  output logic                  ready,
  output logic [NIB-1:0]        hex,
  output logic [NDIG-1:0]       an
);
  localparam int IW = $clog2(NDIG);
  logic tick, frame, accept, commit, blank;
  logic [IW-1:0] idx_q, idx_d;
  logic live_q, live_d, pend_q, pend_d;
  logic [NIB*NDIG-1:0] shadow_q, shadow_d, disp_q, disp_d, rest;
  logic [NIB-1:0] hex_q, hex_d;
  logic [NDIG-1:0] an_q, an_d;
  disp_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  // live_q holds idx at 0 on the first tick after reset so digit 0 lights first
  always_comb begin
    frame = tick & (idx_q == IW'(NDIG - 1));
    accept = load & ~pend_q;
    commit = frame & pend_q;
    idx_d = (tick & live_q) ? ((idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1) : idx_q;
    live_d = live_q | tick;
    shadow_d = accept ? value : shadow_q;
    pend_d = accept | (pend_q & ~commit);
    disp_d = commit ? shadow_q : disp_q;
    rest = disp_d >> (NIB * idx_d);
    blank = LZB_EN && (idx_d != '0) && (rest == '0);
    hex_d = tick ? (blank ? '0 : rest[NIB-1:0]) : hex_q;
    an_d = tick ? (blank ? '1 : ~(NDIG'(1) << idx_d)) : an_q;
  end
  // scan, handshake and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx_q <= '0;
      live_q <= 1'b0;
      pend_q <= 1'b0;
      shadow_q <= '0;
      disp_q <= '0;
      hex_q <= '0;
      an_q <= '1;
    end else begin
      idx_q <= idx_d;
      live_q <= live_d;
      pend_q <= pend_d;
      shadow_q <= shadow_d;
      disp_q <= disp_d;
      hex_q <= hex_d;
      an_q <= an_d;
    end
  assign ready = ~pend_q;
  assign hex = hex_q;
  assign an = an_q;
endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: randomized and directed self-checking bench for disp_scan against a slot-arithmetic model
module tb_disp_scan;
  localparam int NDIG = 4;
  localparam int DIV = 4;
`ifdef DISP_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] value = '0;
  logic ready;
  logic [3:0] hex, an;
  int errs = 0, checks = 0;
  int mc;
  bit m_pend;
  logic [15:0] m_shadow, m_disp;
  logic [3:0] m_hex, m_an;
  always #5 clk = ~clk;
  disp_scan #(.NDIG(NDIG), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .ready(ready), .hex(hex), .an(an)
  );
  task automatic model_reset;
    mc = 0;
    m_pend = 0;
    m_shadow = '0;
    m_disp = '0;
    m_hex = '0;
    m_an = 4'hF;
  endtask
  // one clock edge; the model works from the slot number since reset release
  task automatic step(input bit ld, input logic [15:0] v);
    int t, d;
    bit acc;
    load = ld;
    value = v;
    @(posedge clk);
    #1;
    t = mc / DIV + 1;
    acc = ld && !m_pend;
    if ((mc % DIV) == DIV - 1) begin
      if (t > 1 && (t - 1) % NDIG == 0 && m_pend) begin
        m_disp = m_shadow;
        m_pend = 0;
      end
      d = (t - 1) % NDIG;
      if (LZB && d > 0 && (m_disp >> (4 * d)) == 0) begin
        m_hex = '0;
        m_an = 4'hF;
      end else begin
        m_hex = m_disp[4*d +: 4];
        m_an = ~(4'b1 << d);
      end
    end
    if (acc) begin
      m_shadow = v;
      m_pend = 1;
    end
    mc++;
  endtask
  task automatic test_reset;
    @(negedge clk) rst = 0;
    model_reset();
    step(1, 16'h1234);
    repeat (3 * NDIG * DIV) step(0, '0);
    checks++;
    if (an === 4'hF) begin errs++; $display("FAIL reset_pre: an=%b, want a lit digit", an); end
    #2 rst = 1;
    #1;
    checks++;
    if ({an, hex, ready} !== {4'hF, 4'h0, 1'b1}) begin errs++; $display("FAIL reset_async: an=%b hex=%h ready=%b, want 1111 0 1", an, hex, ready); end
    @(posedge clk);
    #1;
    checks++;
    if ({an, hex, ready} !== {4'hF, 4'h0, 1'b1}) begin errs++; $display("FAIL reset_hold: an=%b hex=%h ready=%b, want 1111 0 1", an, hex, ready); end
    @(negedge clk) rst = 0;
    model_reset();
    repeat (DIV - 1) step(0, '0);
    checks++;
    if (an !== 4'hF) begin errs++; $display("FAIL reset_blank: an=%b, want 1111", an); end
    step(0, '0);
    checks++;
    if ({an, hex} !== {4'hE, 4'h0}) begin errs++; $display("FAIL reset_first: an=%b hex=%h, want 1110 0", an, hex); end
  endtask
  task automatic test_scan;
    logic [7:0] exp [4] = '{8'hD3, 8'hB2, 8'h71, 8'hE4};
    int n = 0;
    step(1, 16'h1234);
    while (n < 3 * NDIG * DIV && !(an === 4'hE && hex === 4'h4)) begin step(0, '0); n++; end
    checks++;
    if (!(an === 4'hE && hex === 4'h4)) begin errs++; $display("FAIL scan_commit: timeout an=%b hex=%h, want 1110 4", an, hex); end
    for (int k = 0; k < 4; k++) begin
      repeat (DIV) step(0, '0);
      checks++;
      if ({an, hex} !== exp[k]) begin errs++; $display("FAIL scan_slot%0d: got %h, want %h", k, {an, hex}, exp[k]); end
    end
  endtask
  task automatic test_handshake;
    logic [7:0] exp [4] = '{8'hED, 8'hDC, 8'hBB, 8'h7A};
    int n = 0;
    step(1, 16'hABCD);
    checks++;
    if (ready !== 1'b0) begin errs++; $display("FAIL hs_busy: ready=%b, want 0", ready); end
    step(1, 16'h5555);
    checks++;
    if (ready !== 1'b0 || m_shadow !== 16'hABCD) begin errs++; $display("FAIL hs_ignore: ready=%b, want 0", ready); end
    while (n < 3 * NDIG * DIV && ready !== 1'b1) begin step(0, '0); n++; end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({an, hex, ready} !== {exp[k], 1'b1}) begin errs++; $display("FAIL hs_slot%0d: got %h ready=%b, want %h ready=1", k, {an, hex}, ready, exp[k]); end
      repeat (DIV) step(0, '0);
    end
  endtask
  task automatic test_tear;
    int n = 0;
    while (n < 3 * NDIG * DIV && an !== 4'hD) begin step(0, '0); n++; end
    step(1, 16'hFFFF);
    repeat (DIV - 1) step(0, '0);
    checks++;
    if ({an, hex} !== 8'hBB) begin errs++; $display("FAIL tear_slot2: got %h, want bb", {an, hex}); end
    repeat (DIV) step(0, '0);
    checks++;
    if ({an, hex} !== 8'h7A) begin errs++; $display("FAIL tear_slot3: got %h, want 7a", {an, hex}); end
    repeat (DIV) step(0, '0);
    checks++;
    if ({an, hex} !== 8'hEF) begin errs++; $display("FAIL tear_next: got %h, want ef", {an, hex}); end
  endtask
  task automatic test_blank;
    logic [7:0] e70 [4], e00 [4];
    int n;
    e70 = LZB ? '{8'hE0, 8'hD7, 8'hF0, 8'hF0} : '{8'hE0, 8'hD7, 8'hB0, 8'h70};
    e00 = LZB ? '{8'hE0, 8'hF0, 8'hF0, 8'hF0} : '{8'hE0, 8'hD0, 8'hB0, 8'h70};
    for (int p = 0; p < 2; p++) begin
      n = 0;
      while (n < 3 * NDIG * DIV && ready !== 1'b1) begin step(0, '0); n++; end
      step(1, p == 0 ? 16'h0070 : 16'h0000);
      n = 0;
      while (n < 3 * NDIG * DIV && ready !== 1'b1) begin step(0, '0); n++; end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({an, hex} !== (p == 0 ? e70[k] : e00[k])) begin errs++; $display("FAIL blank%0d_slot%0d: got %h, want %h", p, k, {an, hex}, p == 0 ? e70[k] : e00[k]); end
        repeat (DIV) step(0, '0);
      end
    end
  endtask
  task automatic test_boundary;
    int n = 0;
    while (n < 4 * NDIG * DIV && !(!m_pend && (mc % DIV) == DIV - 1 && mc / DIV > 0 && (mc / DIV) % NDIG == 0)) begin step(0, '0); n++; end
    step(1, 16'h2468);
    checks++;
    if (ready !== 1'b0) begin errs++; $display("FAIL bnd_accept: ready=%b, want 0", ready); end
    n = 0;
    while (n < 100 && ready !== 1'b1) begin step(0, '0); n++; end
    checks++;
    if (n != 4 * DIV) begin errs++; $display("FAIL bnd_latency: commit after %0d cycles, want %0d", n, 4 * DIV); end
    checks++;
    if ({an, hex} !== 8'hE8) begin errs++; $display("FAIL bnd_digit: got %h, want e8", {an, hex}); end
  endtask
  task automatic test_random;
    logic [15:0] v;
    bit ld;
    for (int i = 0; i < 600; i++) begin
      ld = $urandom_range(0, 5) == 0;
      v = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v[15:8] = '0;
      if ($urandom_range(0, 3) == 0) v[15:4] = '0;
      step(ld, v);
      checks++;
      if ({an, hex, ready} !== {m_an, m_hex, !m_pend}) begin
        errs++;
        $display("FAIL random@%0d: an=%b hex=%h ready=%b, want an=%b hex=%h ready=%b", i, an, hex, ready, m_an, m_hex, !m_pend);
      end
    end
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_scan();
    test_handshake();
    test_tear();
    test_blank();
    test_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DIV, default 50000, meaning clk cycles per digit slot (>=2).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  request to accept value.
REQ-006 SHALL have port value  input  4*NDIG  hex nibbles, nibble 0 = least-significant digit at value[3:0].
REQ-007 SHALL have port ready  output  1  high when load is accepted.
REQ-008 SHALL have port hex  output  4  nibble for the downstream 7-segment decoder input A.
REQ-009 SHALL have port an  output  NDIG  one-hot active-low digit enables; all-ones means blank.

Function
REQ-010 SHALL count a prescaler 0..DIV-1 and wrap; tick is high during the cycle when count==DIV-1.
REQ-011 SHALL hold a digit index idx 0..NDIG-1; on each tick, idx advances by one; NDIG-1 wraps to 0.
REQ-012 SHALL define a frame boundary as a tick with idx==NDIG-1.
REQ-013 SHALL capture value into a shadow register on an edge with load & ready; the same edge sets pend=1, and ready is low from the next cycle.
REQ-014 SHALL ignore load while ready is low; the shadow register is unchanged.
REQ-015 SHALL copy shadow into the display register at a frame boundary edge when pend=1; the same edge clears pend, and ready is high from the next cycle.
REQ-016 SHALL commit a load accepted on a frame-boundary edge at the next frame boundary, not the current one.
REQ-017 SHALL register hex and an; on each tick edge, they take the nibble and enable for the new idx, using the display register value after any same-edge commit.
REQ-018 SHALL leave hex and an unchanged between ticks; latency from tick to new outputs is one edge.
REQ-019 SHALL drive an[idx] low and all other an bits high while a digit is shown.
REQ-020 SHALL drive ready = ~pend.

Reset
REQ-021 SHALL set the following on rst, asynchronously and at any time including mid-frame: prescaler=0, idx=0, pend=0, shadow=0, display=0, hex=0, an=all-ones.
REQ-022 SHALL drive ready high as soon as rst is asserted.
REQ-023 SHALL place the first non-blank output (digit 0) on the first tick after rst deasserts, DIV cycles after release.

Configuration
REQ-024 SHALL, when macro DISP_SCAN_LZB_EN is defined, blank leading zeros.
- A digit k>0 is blank when display nibbles k..NDIG-1 are all zero.
- A blank slot drives an=all-ones and hex=0.
- Digit 0 is never blanked.
REQ-025 SHALL show every digit, including leading zeros, when DISP_SCAN_LZB_EN is undefined.

Structure
REQ-026 SHALL keep NDIG/DIV defaults, the nibble width constant (4) and the blank-enable constant in shared package disp_pkg.
REQ-027 SHALL place the prescaler in sub-module disp_tick.
- Ports: clk, rst, tick.
- Parameter: DIV.
REQ-028 SHALL implement idx, the handshake, blanking and output registers in disp_scan.

Verification (NDIG=4, DIV=4)
REQ-029 SHALL check reset: assert rst mid-slot with value 16'h1234 displayed -> next edge region shows hex=0, an=4'b1111, ready=1; after release, first tick gives an=4'b1110, hex=0.
REQ-030 SHALL check scan: load 16'h1234 -> after commit, successive ticks give (an,hex) = (1110,4), (1101,3), (1011,2), (0111,1), then wrap to (1110,4).
REQ-031 SHALL check the handshake: load 16'hABCD, then load 16'h5555 one cycle later -> ready=0, second load ignored; after the next frame boundary, digits show D,C,B,A and ready=1.
REQ-032 SHALL check tear-free update: load 16'hFFFF while idx=1 -> slots 2 and 3 of the current frame still show the old value; the new value appears from slot 0 of the next frame.
REQ-033 SHALL check leading-zero blanking: with DISP_SCAN_LZB_EN, load 16'h0070 -> slots show (1110,0), (1101,7), (1111,0), (1111,0); load 16'h0000 -> only slot 0 is lit; without the macro, all four slots are lit.
REQ-034 SHALL check a load on the boundary: load asserted on a frame-boundary edge -> commit occurs exactly 4*DIV=16 cycles later.
